// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 word master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    WAIT,
    HOLD,
    GAP
  } spi_state_e;

  localparam int unsigned SPI_WORD_W = 16;
  localparam logic        SCLK_IDLE  = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period tick generator: tick on count CLK_DIV-1, restartable.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: streams WIDTH-bit words MSB first on MOSI, captures MISO,
// frames CS around each io_in_last-terminated burst.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH    = SPI_WORD_W,
  parameter int unsigned CLK_DIV  = 25,
  parameter int unsigned CS_SETUP = 1,
  parameter int unsigned CS_GAP   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_data,
  input  logic             io_in_last,
  output logic             io_rx_valid,
  output logic [WIDTH-1:0] io_rx_data,
  output logic             io_busy,
  output logic             io_spi_sclk,
  output logic             io_spi_mosi,
  output logic             io_spi_cs,
  input  logic             io_spi_miso
);

  localparam int unsigned BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CNT_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  spi_state_e r_state, w_state_nxt;

  logic [WIDTH-1:0] r_tx, r_rx, r_rx_data;
  logic [BW-1:0]    r_bit;
  logic [CW-1:0]    r_cnt;
  logic             r_last, r_sclk, r_mosi, r_cs, r_rx_valid, r_rx_done;

  logic w_tick, w_restart, w_ready, w_load, w_rise, w_fall, w_cs_off;
  logic w_bit_last, w_setup_done, w_gap_done;

  assign w_bit_last   = (r_bit == BW'(WIDTH - 1));
  assign w_setup_done = (r_cnt == CW'(CS_SETUP - 1));
  assign w_gap_done   = (r_cnt == CW'(CS_GAP - 1));

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clock   (clock),
    .reset   (reset),
    .restart (w_restart),
    .tick    (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The final SETUP tick already produces the first rising edge, so the first
  // SCLK rise lands CS_SETUP half-periods after CS falls.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_load      = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_cs_off    = 1'b0;
    case (r_state)
      IDLE, WAIT: begin
        w_ready = 1'b1;
        if (io_in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (w_tick && w_setup_done) begin
          w_rise      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_tick) begin
          if (r_sclk == SCLK_IDLE) begin
            w_rise = 1'b1;
          end else begin
            w_fall = 1'b1;
            if (w_bit_last) begin
              if (r_last) begin
                w_state_nxt = HOLD;
              end else begin
                w_ready = 1'b1;
                if (io_in_valid) begin
                  w_load = 1'b1;
                end else begin
                  w_state_nxt = WAIT;
                end
              end
            end
          end
        end
      end
      HOLD: begin
        if (w_tick) begin
          w_cs_off    = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (w_tick && w_gap_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_restart = (w_state_nxt != r_state);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_bit      <= '0;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      r_sclk     <= SCLK_IDLE;
      r_mosi     <= 1'b0;
      r_cs       <= 1'b1;
      r_rx_valid <= 1'b0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_done  <= 1'b0;
      if (w_restart) begin
        r_cnt <= '0;
      end else if (w_tick && (r_state == SETUP || r_state == GAP)) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_rise) begin
        r_sclk    <= ~SCLK_IDLE;
        r_rx      <= {r_rx[WIDTH-2:0], io_spi_miso};
        r_rx_done <= w_bit_last;
      end
      if (r_rx_done) begin
        r_rx_data  <= r_rx;
        r_rx_valid <= 1'b1;
      end
      if (w_fall) begin
        r_sclk <= SCLK_IDLE;
        if (!w_bit_last) begin
          r_bit  <= r_bit + BW'(1);
          r_tx   <= {r_tx[WIDTH-2:0], 1'b0};
          r_mosi <= r_tx[WIDTH-2];
        end
      end
      // A load on the 16th fall overrides the shift so the next word starts at once.
      if (w_load) begin
        r_tx   <= io_in_data;
        r_last <= io_in_last;
        r_mosi <= io_in_data[WIDTH-1];
        r_cs   <= 1'b0;
        r_bit  <= '0;
      end
      if (w_cs_off) begin
        r_cs   <= 1'b1;
        r_mosi <= 1'b0;
      end
    end
  end

  assign io_in_ready = w_ready;
  assign io_rx_valid = r_rx_valid;
  assign io_rx_data  = r_rx_data;
  assign io_busy     = (r_state != IDLE) || w_load;
  assign io_spi_sclk = r_sclk;
  assign io_spi_mosi = r_mosi;
  assign io_spi_cs   = r_cs;

endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: two instances (CLK_DIV 25 and 2), MISO looped to MOSI.
module tb_spi_master_tx;

  localparam int DIV0   = 25;
  localparam int DIV1   = 2;
  localparam int CS_GAP = 2;

  localparam int C_SCLK_HI = 0, C_SCLK_LO = 1, C_CS_HI = 2, C_READY = 4, C_IDLE = 5, C_RISE7 = 6;

  logic clk, rst;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [15:0] in_data  [2];
  logic        in_last  [2];
  logic        rx_valid [2];
  logic [15:0] rx_data  [2];
  logic        busy     [2];
  logic        sclk     [2];
  logic        mosi     [2];
  logic        cs       [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_master_tx #(
      .WIDTH    (16),
      .CLK_DIV  ((g == 0) ? DIV0 : DIV1),
      .CS_SETUP (1),
      .CS_GAP   (CS_GAP)
    ) u_dut (
      .clock       (clk),
      .reset       (rst),
      .io_in_valid (in_valid[g]),
      .io_in_ready (in_ready[g]),
      .io_in_data  (in_data[g]),
      .io_in_last  (in_last[g]),
      .io_rx_valid (rx_valid[g]),
      .io_rx_data  (rx_data[g]),
      .io_busy     (busy[g]),
      .io_spi_sclk (sclk[g]),
      .io_spi_mosi (mosi[g]),
      .io_spi_cs   (cs[g]),
      .io_spi_miso (mosi[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] exp_tx_q[$];
  logic [15:0] exp_rx_q[$];
  int          exp_frame_q[$];

  int          frame_words [2] = '{0, 0};
  int          bits        [2] = '{0, 0};
  logic [15:0] sbuf        [2];
  int          frame_rises [2] = '{0, 0};
  int          last_rise   [2] = '{0, 0};
  int          rise16      [2] = '{0, 0};
  int          last_csr    [2] = '{-1, -1};
  bit          rx_pend     [2] = '{0, 0};
  int          rxv_cnt     [2] = '{0, 0};
  int          ready_cs_cnt[2] = '{0, 0};
  bit          track_busy  [2] = '{0, 0};
  int          busy_low    [2] = '{0, 0};
  logic        prev_sclk   [2] = '{1'b0, 1'b0};
  logic        prev_cs     [2] = '{1'b1, 1'b1};

  function automatic int div_of(input int g);
    return (g == 0) ? DIV0 : DIV1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit cond(input int g, input int code);
    case (code)
      C_SCLK_HI: return sclk[g] === 1'b1;
      C_SCLK_LO: return sclk[g] === 1'b0;
      C_CS_HI:   return cs[g] === 1'b1;
      C_READY:   return in_ready[g] === 1'b1;
      C_IDLE:    return busy[g] === 1'b0;
      C_RISE7:   return frame_rises[g] >= 7;
      default:   return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int g, input int code, input int budget, input string name, output int at);
    int n = 0;
    while (!cond(g, code) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!cond(g, code)) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: timeout, condition not reached within %0d cycles", name, budget);
    end
    at = cyc;
  endtask

  // Present a word; returns the cycle at which ready was seen (accept on the next edge).
  task automatic send(input int g, input logic [15:0] d, input logic l, input bit hold, output int acc);
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    in_last[g]  = l;
    wait_cond(g, C_READY, 5000, "accept_timeout", acc);
    exp_tx_q.push_back(d);
    exp_rx_q.push_back(d);
    frame_words[g]++;
    if (l) begin
      exp_frame_q.push_back(frame_words[g]);
      frame_words[g] = 0;
    end
    @(negedge clk);
    if (!hold) in_valid[g] = 1'b0;
    in_data[g] = 16'($urandom);
    in_last[g] = 1'($urandom);
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        bits[g] = 0;
        frame_rises[g] = 0;
        rx_pend[g] = 1'b0;
        last_csr[g] = -1;
      end else begin
        if (sclk[g] && !prev_sclk[g]) begin
          sbuf[g] = {sbuf[g][14:0], mosi[g]};
          bits[g]++;
          frame_rises[g]++;
          last_rise[g] = cyc;
          if (bits[g] == 16) begin
            bits[g] = 0;
            chk("slave_word_expected", 32'(exp_tx_q.size() > 0), 1);
            if (exp_tx_q.size() > 0) chk("slave_word", sbuf[g], exp_tx_q.pop_front());
            chk("rx_valid_before_next_word", rx_pend[g], 0);
            rx_pend[g] = 1'b1;
            rise16[g] = cyc;
          end
        end
        if (rx_valid[g]) begin
          rxv_cnt[g]++;
          chk("rx_valid_expected", rx_pend[g], 1);
          chk("rx_valid_after_16th_rise",
              32'((cyc - rise16[g] >= 1) && (cyc - rise16[g] < div_of(g))), 1);
          chk("rx_word_expected", 32'(exp_rx_q.size() > 0), 1);
          if (exp_rx_q.size() > 0) chk("rx_data", rx_data[g], exp_rx_q.pop_front());
          rx_pend[g] = 1'b0;
        end
        if (cs[g] && !prev_cs[g]) begin
          chk("frame_expected", 32'(exp_frame_q.size() > 0), 1);
          if (exp_frame_q.size() > 0) chk("frame_sclk_rises", frame_rises[g], 16 * exp_frame_q.pop_front());
          frame_rises[g] = 0;
          last_csr[g] = cyc;
        end
        if (!cs[g] && prev_cs[g] && last_csr[g] >= 0)
          chk("cs_gap_min", 32'((cyc - last_csr[g]) >= CS_GAP * div_of(g)), 1);
        if (in_ready[g] && !cs[g]) ready_cs_cnt[g]++;
        if (track_busy[g] && !busy[g]) busy_low[g]++;
      end
      prev_sclk[g] = sclk[g];
      prev_cs[g]   = cs[g];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a2, t, t0, tf, tc, bad;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0;
      in_data[g]  = '0;
      in_last[g]  = 1'b0;
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset_cs", cs[g], 1);
      chk("reset_sclk", sclk[g], 0);
      chk("reset_mosi", mosi[g], 0);
      chk("reset_rx_valid", rx_valid[g], 0);
      chk("reset_rx_data", rx_data[g], 0);
      chk("reset_busy", busy[g], 0);
      chk("reset_ready", in_ready[g], 1);
    end

    // 1: single word, timing of CS and SCLK
    send(0, 16'h0064, 1'b1, 1'b0, a);
    chk("t1_cs_low_after_accept", cs[0], 0);
    chk("t1_busy_after_accept", busy[0], 1);
    wait_cond(0, C_SCLK_HI, 200, "t1_first_rise", t);
    chk("t1_first_rise_delay", t - a, 1 + DIV0);
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      wait_cond(0, C_SCLK_LO, 200, "t1_fall", tf);
      wait_cond(0, C_SCLK_HI, 200, "t1_rise", tc);
      if (tc - t != 2 * DIV0) bad++;
      t = tc;
    end
    chk("t1_sclk_period_bad", bad, 0);
    wait_cond(0, C_SCLK_LO, 200, "t1_last_fall", tf);
    wait_cond(0, C_CS_HI, 200, "t1_cs_rise", tc);
    chk("t1_cs_rise_after_last_fall", tc - tf, DIV0);
    wait_cond(0, C_IDLE, 500, "t1_idle", t);

    // 2: back-to-back words in one frame
    ready_cs_cnt[0] = 0;
    send(0, 16'h0000, 1'b0, 1'b0, a);
    wait_cond(0, C_SCLK_HI, 200, "t2_first_rise", t0);
    send(0, 16'h0064, 1'b1, 1'b0, a2);
    chk("t2_ready_at_16th_fall", a2 - last_rise[0], DIV0 - 1);
    chk("t2_rises_at_ready", frame_rises[0], 16);
    wait_cond(0, C_CS_HI, 2000, "t2_cs_rise", tc);
    chk("t2_contiguous_span", last_rise[0] - t0, 31 * 2 * DIV0);
    chk("t2_ready_pulses", ready_cs_cnt[0], 1);
    wait_cond(0, C_IDLE, 500, "t2_idle", t);

    // 3: underrun holds CS low with SCLK idle, then resumes after setup
    send(0, 16'h1234, 1'b0, 1'b0, a);
    wait_cond(0, C_READY, 2000, "t3_wait_ready", t);
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (sclk[0] !== 1'b0 || cs[0] !== 1'b0 || in_ready[0] !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("t3_underrun_hold_bad", bad, 0);
    send(0, 16'hABCD, 1'b1, 1'b0, a);
    wait_cond(0, C_SCLK_HI, 200, "t3_resume_rise", t);
    chk("t3_resume_setup", t - a, 1 + DIV0);
    wait_cond(0, C_IDLE, 2000, "t3_idle", t);

    // 4: loopback, one rx_valid per word
    rxv_cnt[0] = 0;
    send(0, 16'hA5C3, 1'b0, 1'b0, a);
    send(0, 16'h0F0F, 1'b1, 1'b0, a);
    wait_cond(0, C_IDLE, 2000, "t4_idle", t);
    chk("t4_rx_valid_count", rxv_cnt[0], 2);

    // 5: reset mid-word
    rxv_cnt[0] = 0;
    send(0, 16'hFFFF, 1'b1, 1'b0, a);
    wait_cond(0, C_RISE7, 1000, "t5_seven_rises", t);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_cs_after_reset", cs[0], 1);
    chk("t5_sclk_after_reset", sclk[0], 0);
    chk("t5_rx_valid_after_reset", rx_valid[0], 0);
    exp_tx_q.delete();
    exp_rx_q.delete();
    exp_frame_q.delete();
    frame_words[0] = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ready_after_reset", in_ready[0], 1);
    send(0, 16'h3C5A, 1'b1, 1'b0, a);
    wait_cond(0, C_IDLE, 2000, "t5_idle", t);
    chk("t5_rx_valid_count", rxv_cnt[0], 1);

    // 6: CLK_DIV=2, single-word frames with valid held high
    send(1, 16'($urandom), 1'b1, 1'b1, a);
    track_busy[1] = 1'b1;
    send(1, 16'($urandom), 1'b1, 1'b0, a);
    track_busy[1] = 1'b0;
    chk("t6_busy_continuous", busy_low[1], 0);
    wait_cond(1, C_IDLE, 500, "t6_idle", t);

    // random stream: mixed frame lengths, held valid, idle gaps and underruns
    for (int i = 0; i < 40; i++) begin
      logic l;
      bit   h;
      l = (i == 39) || ($urandom_range(0, 2) == 0);
      h = (i != 39) && ($urandom_range(0, 1) == 1);
      send(1, 16'($urandom), l, h, a);
      if (!h) repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    wait_cond(1, C_IDLE, 2000, "rand_idle", t);
    wait_cond(0, C_IDLE, 10, "dut0_idle", t);
    repeat (5) @(negedge clk);

    chk("end_tx_queue_empty", exp_tx_q.size(), 0);
    chk("end_rx_queue_empty", exp_rx_q.size(), 0);
    chk("end_frame_queue_empty", exp_frame_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
